button_debounce: RTL and testbench
==================================

// Module: button_debounce
// PURPOSE
//   Input-side GPIO reader for the 27 MHz board.
//   - Samples a raw, asynchronous push-button pin; active level set by ACTIVE_LOW.
//   - Synchronises and debounces the pin, then reports a clean level.
//   - Emits single-cycle press, release and long-press pulses plus a wrapping press counter.
//   - Sits between a board pin and user logic (e.g. LED pattern/rate control).
// PARAMETERS
//   CLK_FREQ       27_000_000  clk frequency in Hz
//   DEBOUNCE_MS    10          pin must be stable this long before a change is accepted
//   LONG_PRESS_MS  1000        hold time, measured from accepted press, that fires long_pulse
//   ACTIVE_LOW     1           1: pin reads 0 when pressed; 0: pin reads 1 when pressed
//   Derived (localparam):
//     DEB_CYCLES  = CLK_FREQ/1000*DEBOUNCE_MS    (270_000 at default)
//     LONG_CYCLES = CLK_FREQ/1000*LONG_PRESS_MS  (27_000_000 at default)
//   Both must be >= 2; elaboration fails otherwise.
// PORTS
//   clk            in   1  system clock
//   rst            in   1  asynchronous, active-high reset
//   btn_in         in   1  raw pin; asynchronous to clk
//   btn_level      out  1  debounced state, 1 = pressed
//   press_pulse    out  1  1-cycle strobe on accepted press
//   release_pulse  out  1  1-cycle strobe on accepted release
//   long_pulse     out  1  1-cycle strobe, at most once per press
//   press_count    out  8  count of accepted presses; wraps 255 -> 0
// BEHAVIOUR
//   Reset: all outputs 0; FSM = RELEASED; counters 0; synchroniser flops = inactive pin level.
//   Input path: 2-FF synchroniser, then raw_p = sync_out XOR ACTIVE_LOW.
//   FSM, debounce counter cnt:
//     RELEASED:    if raw_p, go to PRESS_PEND with cnt = 0.
//     PRESS_PEND:  if !raw_p, go to RELEASED (glitch dropped, no output).
//                  else if cnt == DEB_CYCLES-1, go to PRESSED:
//                    - press_pulse = 1 for one cycle
//                    - btn_level = 1
//                    - press_count += 1
//                    - long counter lcnt = 0
//                  else cnt += 1.
//     PRESSED:     if !raw_p, go to REL_PEND with cnt = 0.
//     REL_PEND:    if raw_p, return to PRESSED; this is a bounce and lcnt is not cleared.
//                  else if cnt == DEB_CYCLES-1, go to RELEASED:
//                    - release_pulse = 1 for one cycle
//                    - btn_level = 0
//                    - lcnt and long_fired cleared
//                  else cnt += 1.
//   Long press:
//     - lcnt increments in PRESSED and REL_PEND and saturates.
//     - When lcnt == LONG_CYCLES-1 and !long_fired: long_pulse = 1 and long_fired = 1.
//   Latency: first edge sampling the new pin level = edge 1.
//     - press_pulse / release_pulse are high in the cycle after edge DEB_CYCLES+3.
//     - long_pulse is high LONG_CYCLES cycles after press_pulse.
//   All outputs are registered.
//   Simultaneous events:
//     - Release confirmation and long threshold in the same cycle: release wins, long_pulse suppressed.
//     - press_pulse and release_pulse never coincide.
//   Reset mid-operation: immediate asynchronous clear.
//     - A button still held after rst deasserts goes through the full debounce.
//     - It then produces a fresh press_pulse and press_count = 1.
//   Widths: cnt = $clog2(DEB_CYCLES); lcnt = $clog2(LONG_CYCLES); no overflow beyond saturation.
// STRUCTURE
//   Shared package gpio_pkg:
//     - FSM state encoding (RELEASED, PRESS_PEND, PRESSED, REL_PEND)
//     - ms_to_cycles(freq, ms) constant function
//   Sub-module sync_2ff (1-bit, reset value parameter); reused for other board inputs.
//   Everything else lives in this module: FSM, debounce counter, long counter, press counter.
// TESTING
//   Bench parameters: CLK_FREQ=100_000, DEBOUNCE_MS=1 (DEB=100), LONG_PRESS_MS=5 (LONG=500),
//   ACTIVE_LOW=1.
//   1. Clean press: hold btn_in=0 for 300 cycles.
//      -> press_pulse single-cycle, high in the cycle after edge 103; btn_level=1; press_count=1.
//   2. Glitch: pulse btn_in=0 for 50 cycles, then 1.
//      -> no pulses; btn_level stays 0; press_count stays 0.
//   3. Bouncy release: from pressed, toggle the pin every 20 cycles for 200 cycles, then hold 1.
//      -> exactly one release_pulse, 103 cycles after the final edge.
//      -> no extra press_pulse.
//   4. Long press: hold 0 for 800 cycles.
//      -> long_pulse exactly once, 500 cycles after press_pulse.
//      -> no second long_pulse while the button stays held.
//   5. Counter wrap: 256 clean press/release pairs.
//      -> press_count = 0 after the last press; one press_pulse each.
//   6. Reset mid-press: assert rst while pressed, keep the pin held, release rst.
//      -> all outputs 0 immediately.
//      -> press_pulse 103 cycles later; press_count = 1.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared definitions for board GPIO input handling: debounce FSM encoding
// and a millisecond-to-cycle conversion used to size timers.
package gpio_pkg;

  typedef enum logic [1:0] {
    RELEASED   = 2'd0,
    PRESS_PEND = 2'd1,
    PRESSED    = 2'd2,
    REL_PEND   = 2'd3
  } btn_state_t;

  function automatic int unsigned ms_to_cycles(input int unsigned freq, input int unsigned ms);
    return freq / 1000 * ms;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
// RESET_VAL should match the idle level of the pin so reset produces no false edge.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Push-button reader: synchronises and debounces a raw pin, then reports a clean
// level plus press/release/long-press strobes and a wrapping press counter.
module button_debounce
  import gpio_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = 27_000_000,
  parameter int unsigned DEBOUNCE_MS   = 10,
  parameter int unsigned LONG_PRESS_MS = 1000,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [7:0] press_count
);

  localparam int unsigned DEB_CYCLES  = ms_to_cycles(CLK_FREQ, DEBOUNCE_MS);
  localparam int unsigned LONG_CYCLES = ms_to_cycles(CLK_FREQ, LONG_PRESS_MS);
  localparam int CNT_W  = (DEB_CYCLES  > 1) ? $clog2(DEB_CYCLES)  : 1;
  localparam int LCNT_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [LCNT_W-1:0] LONG_LAST = LCNT_W'(LONG_CYCLES - 1);

  generate
    if (DEB_CYCLES < 2 || LONG_CYCLES < 2) begin : g_bad_timing
      $error("button_debounce: DEB_CYCLES and LONG_CYCLES must both be >= 2");
    end
  endgenerate

  logic              sync_out;
  logic              raw_p;
  btn_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [LCNT_W-1:0] lcnt;
  logic              long_fired;
  logic              held;

  sync_2ff #(
    .RESET_VAL(ACTIVE_LOW)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (btn_in),
    .q  (sync_out)
  );

  // Normalise polarity so raw_p = 1 means "pressed" regardless of wiring.
  assign raw_p = sync_out ^ ACTIVE_LOW;
  assign held  = (state == PRESSED) || (state == REL_PEND);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RELEASED;
      cnt           <= '0;
      lcnt          <= '0;
      long_fired    <= 1'b0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;

      // Hold timer keeps running through release bounces and saturates at threshold.
      if (held && lcnt != LONG_LAST) begin
        lcnt <= lcnt + LCNT_W'(1);
      end
      if (held && lcnt == LONG_LAST && !long_fired) begin
        long_pulse <= 1'b1;
        long_fired <= 1'b1;
      end

      case (state)
        RELEASED: begin
          if (raw_p) begin
            state <= PRESS_PEND;
            cnt   <= '0;
          end
        end
        PRESS_PEND: begin
          if (!raw_p) begin
            state <= RELEASED;
          end else if (cnt == DEB_LAST) begin
            state       <= PRESSED;
            press_pulse <= 1'b1;
            btn_level   <= 1'b1;
            press_count <= press_count + 8'd1;
            lcnt        <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!raw_p) begin
            state <= REL_PEND;
            cnt   <= '0;
          end
        end
        REL_PEND: begin
          if (raw_p) begin
            state <= PRESSED;
          end else if (cnt == DEB_LAST) begin
            // Release takes priority over a long-press threshold hit on the same edge.
            state         <= RELEASED;
            release_pulse <= 1'b1;
            btn_level     <= 1'b0;
            lcnt          <= '0;
            long_fired    <= 1'b0;
            long_pulse    <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= RELEASED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce: expected strobes are queued when the pin is
// driven and matched against the DUT's pulses as they appear.
module tb_button_debounce;

  localparam int DEB      = 100;
  localparam int LONG     = 500;
  localparam int LAT      = DEB + 3;
  localparam int EV_PRESS = 0;
  localparam int EV_REL   = 1;
  localparam int EV_LONG  = 2;

  typedef struct {
    int         kind;
    int         cyc;
    logic [7:0] count;
  } exp_ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_in = 1'b1;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic [7:0] press_count;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] exp_count = 8'd0;
  exp_ev_t    exp_q[$];

  button_debounce #(
    .CLK_FREQ     (100_000),
    .DEBOUNCE_MS  (1),
    .LONG_PRESS_MS(5),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .press_count  (press_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int kind, input int at, input logic [7:0] cnt);
    exp_ev_t e;
    e.kind  = kind;
    e.cyc   = at;
    e.count = cnt;
    exp_q.push_back(e);
  endtask

  task automatic consume(input int kind);
    exp_ev_t e;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL unexpected_pulse: observed kind %0d at cycle %0d expected no pulse", kind, cyc);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_int("event_kind", kind, e.kind);
      check_int($sformatf("event_cycle_kind%0d", kind), cyc, e.cyc);
      if (kind == EV_PRESS) begin
        check_int("press_count_at_press", int'(press_count), int'(e.count));
        check_int("level_at_press", int'(btn_level), 1);
      end else if (kind == EV_REL) begin
        check_int("level_at_release", int'(btn_level), 0);
      end else begin
        check_int("level_at_long", int'(btn_level), 1);
      end
    end
  endtask

  // One clock: sample on the falling edge, match pulses, flag overdue expectations.
  task automatic tick();
    exp_ev_t e;
    @(negedge clk);
    if (!rst) begin
      if (press_pulse)   consume(EV_PRESS);
      if (release_pulse) consume(EV_REL);
      if (long_pulse)    consume(EV_LONG);
    end
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      check_int($sformatf("missing_pulse_kind%0d", e.kind), cyc, e.cyc);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic press(input int hold);
    btn_in = 1'b0;
    exp_count = exp_count + 8'd1;
    expect_ev(EV_PRESS, cyc + LAT, exp_count);
    ticks(hold);
  endtask

  task automatic release_btn(input int hold);
    btn_in = 1'b1;
    expect_ev(EV_REL, cyc + LAT, 8'd0);
    ticks(hold);
  endtask

  initial begin
    // Reset state
    ticks(3);
    check_int("reset_level", int'(btn_level), 0);
    check_int("reset_press", int'(press_pulse), 0);
    check_int("reset_release", int'(release_pulse), 0);
    check_int("reset_long", int'(long_pulse), 0);
    check_int("reset_count", int'(press_count), 0);
    rst = 1'b0;
    ticks(10);
    check_int("idle_level", int'(btn_level), 0);

    // 1. Clean press
    press(300);
    check_int("t1_level", int'(btn_level), 1);
    check_int("t1_count", int'(press_count), int'(exp_count));
    release_btn(200);
    check_int("t1_level_after_release", int'(btn_level), 0);

    // 2. Glitch shorter than the debounce window
    btn_in = 1'b0;
    ticks(50);
    btn_in = 1'b1;
    ticks(200);
    check_int("t2_level", int'(btn_level), 0);
    check_int("t2_count", int'(press_count), int'(exp_count));

    // 3. Bouncy release
    press(150);
    for (int i = 0; i < 10; i++) begin
      btn_in = (i % 2 == 0) ? 1'b1 : 1'b0;
      ticks(20);
    end
    check_int("t3_level_during_bounce", int'(btn_level), 1);
    release_btn(200);
    check_int("t3_level", int'(btn_level), 0);
    check_int("t3_count", int'(press_count), int'(exp_count));

    // 4. Long press: one long pulse LONG cycles after press_pulse
    btn_in = 1'b0;
    exp_count = exp_count + 8'd1;
    expect_ev(EV_PRESS, cyc + LAT, exp_count);
    expect_ev(EV_LONG, cyc + LAT + LONG, 8'd0);
    ticks(800);
    check_int("t4_level", int'(btn_level), 1);
    release_btn(200);

    // Fresh reset so the wrap test starts from zero
    rst = 1'b1;
    ticks(3);
    rst = 1'b0;
    exp_count = 8'd0;
    ticks(5);
    check_int("pre_wrap_count", int'(press_count), 0);

    // 5. Counter wrap over 256 presses
    for (int i = 0; i < 256; i++) begin
      press(108);
      release_btn(108);
    end
    check_int("t5_model_wrapped", int'(exp_count), 0);
    check_int("t5_count_wrapped", int'(press_count), int'(exp_count));

    // 6. Reset while pressed, pin kept held
    press(150);
    check_int("t6_count_before", int'(press_count), 1);
    #2;
    rst = 1'b1;
    #1;
    check_int("t6_rst_level", int'(btn_level), 0);
    check_int("t6_rst_press", int'(press_pulse), 0);
    check_int("t6_rst_release", int'(release_pulse), 0);
    check_int("t6_rst_long", int'(long_pulse), 0);
    check_int("t6_rst_count", int'(press_count), 0);
    ticks(5);
    rst = 1'b0;
    exp_count = 8'd1;
    expect_ev(EV_PRESS, cyc + LAT, exp_count);
    ticks(200);
    check_int("t6_count_after", int'(press_count), 1);
    release_btn(200);

    for (int i = 0; i < 300 && exp_q.size() > 0; i++) tick();
    check_int("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
